// File: rtl/mul_wb_buffer_pkg.sv
// Shared constants and entry type for the multiplier writeback buffer.
package mul_wb_buffer_pkg;
  localparam int MUL_WB_DEPTH = 2;
  localparam int MUL_WB_CNT_W = $clog2(MUL_WB_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mul_wb_entry_t;
endpackage

// File: rtl/mul_wb_fwd.sv
// Youngest-match forwarding lookup over the buffered multiplier results.
module mul_wb_fwd #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][4:0]        rd_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [PTR_W-1:0]             wr_ptr_i,
  input  logic [4:0]                   rs_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  logic [PTR_W-1:0] idx;

  // Walk from the oldest slot (wr_ptr) to the youngest (wr_ptr-1); later matches override.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wr_ptr_i + PTR_W'(k);
      if (vld_i[idx] && (rd_i[idx] == rs_i) && (rs_i != 5'd0)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/mul_wb_buffer.sv
// Result FIFO between the multiplier and the register-file write port,
// with back-pressure to the multiplier and decode-stage forwarding.
module mul_wb_buffer
  import mul_wb_buffer_pkg::*;
#(
  parameter int DEPTH  = MUL_WB_DEPTH,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mul_valid_i,
  input  logic [DATA_W-1:0] mul_result_i,
  input  logic [4:0]        mul_rd_i,
  output logic              ex_ready_o,
  input  logic              flush_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic              wb_ready_i,
  input  logic [4:0]        fwd_rs1_i,
  input  logic [4:0]        fwd_rs2_i,
  output logic              fwd_hit1_o,
  output logic              fwd_hit2_o,
  output logic [DATA_W-1:0] fwd_data1_o,
  output logic [DATA_W-1:0] fwd_data2_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][4:0]        rd_q, rd_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         push, pop;

  // Ready depends only on registered occupancy and reset, never on wb_ready_i/flush_i.
  assign ex_ready_o = (count_q != CNT_W'(DEPTH)) & rst_n;
  assign wb_valid_o = (count_q != '0);
  assign wb_rd_o    = wb_valid_o ? rd_q[rd_ptr_q]   : 5'd0;
  assign wb_data_o  = wb_valid_o ? data_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  // rd==0 results are accepted but dropped: x0 is never written.
  assign push = mul_valid_i & ex_ready_o & (mul_rd_i != 5'd0);
  assign pop  = wb_valid_o & wb_ready_i;

  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      vld_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        vld_d[wr_ptr_q]  = 1'b1;
        rd_d[wr_ptr_q]   = mul_rd_i;
        data_d[wr_ptr_q] = mul_result_i;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q     <= '0;
      data_q   <= '0;
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  mul_wb_fwd #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_fwd1 (
    .rd_i(rd_q), .data_i(data_q), .vld_i(vld_q), .wr_ptr_i(wr_ptr_q),
    .rs_i(fwd_rs1_i), .hit_o(fwd_hit1_o), .data_o(fwd_data1_o)
  );

  mul_wb_fwd #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_fwd2 (
    .rd_i(rd_q), .data_i(data_q), .vld_i(vld_q), .wr_ptr_i(wr_ptr_q),
    .rs_i(fwd_rs2_i), .hit_o(fwd_hit2_o), .data_o(fwd_data2_o)
  );
endmodule

// File: tb/tb_mul_wb_buffer.sv
// Directed plus random bench for mul_wb_buffer against a queue-based reference model.
module tb_mul_wb_buffer;
  import mul_wb_buffer_pkg::*;
  localparam int DEPTH = MUL_WB_DEPTH;
  localparam int DW    = 32;
  localparam int CW    = MUL_WB_CNT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mul_valid = 1'b0;
  logic [DW-1:0] mul_res = '0;
  logic [4:0]    mul_rd = '0;
  logic          flush = 1'b0;
  logic          wb_ready = 1'b0;
  logic [4:0]    rs1 = '0, rs2 = '0;
  logic          ex_ready_o, wb_valid_o, fwd_hit1_o, fwd_hit2_o;
  logic [4:0]    wb_rd_o;
  logic [DW-1:0] wb_data_o, fwd_data1_o, fwd_data2_o;
  logic [CW-1:0] count_o;

  int tests = 0;
  int fails = 0;
  mul_wb_entry_t mq[$];

  always #5 clk = ~clk;

  mul_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mul_valid_i(mul_valid), .mul_result_i(mul_res), .mul_rd_i(mul_rd),
    .ex_ready_o(ex_ready_o), .flush_i(flush),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready),
    .fwd_rs1_i(rs1), .fwd_rs2_i(rs2),
    .fwd_hit1_o(fwd_hit1_o), .fwd_hit2_o(fwd_hit2_o),
    .fwd_data1_o(fwd_data1_o), .fwd_data2_o(fwd_data2_o),
    .count_o(count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference forwarding: newest queued entry with a matching, nonzero rd.
  function automatic void mfwd(input logic [4:0] rs, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (rs != 5'd0)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].rd == rs) begin
          h = 1'b1;
          d = mq[i].data;
          break;
        end
  endfunction

  task automatic tick();
    logic          h;
    logic [DW-1:0] d;
    bit            acc, pop;
    @(negedge clk);
    chk("count", 64'(count_o), 64'(mq.size()));
    chk("ex_ready", 64'(ex_ready_o), 64'(rst_n && mq.size() < DEPTH));
    chk("wb_valid", 64'(wb_valid_o), 64'(mq.size() != 0));
    chk("wb_rd", 64'(wb_rd_o), (mq.size() != 0) ? 64'(mq[0].rd) : 64'd0);
    chk("wb_data", 64'(wb_data_o), (mq.size() != 0) ? 64'(mq[0].data) : 64'd0);
    mfwd(rs1, h, d);
    chk("fwd_hit1", 64'(fwd_hit1_o), 64'(h));
    chk("fwd_data1", 64'(fwd_data1_o), 64'(d));
    mfwd(rs2, h, d);
    chk("fwd_hit2", 64'(fwd_hit2_o), 64'(h));
    chk("fwd_data2", 64'(fwd_data2_o), 64'(d));
    acc = mul_valid && rst_n && (mq.size() < DEPTH);
    pop = wb_ready && (mq.size() != 0);
    @(posedge clk);
    if (!rst_n || flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc && mul_rd != 5'd0) mq.push_back('{rd: mul_rd, data: mul_res});
    end
    #1;
  endtask

  task automatic drv(input bit v, input logic [4:0] rd, input logic [DW-1:0] dat,
                     input bit wr, input bit fl, input logic [4:0] r1, input logic [4:0] r2);
    mul_valid = v;
    mul_rd    = rd;
    mul_res   = dat;
    wb_ready  = wr;
    flush     = fl;
    rs1       = r1;
    rs2       = r2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();                                          // reset state

    // single push, popped one cycle later
    drv(1, 5, 32'h1234_5678, 1, 0, 5, 0); tick();
    drv(0, 0, 0, 1, 0, 5, 0);            tick();
    tick();

    // fill with no grant, third result refused, then drain in order
    drv(1, 1, 32'hA, 0, 0, 1, 2); tick();
    drv(1, 2, 32'hB, 0, 0, 1, 2); tick();
    drv(1, 3, 32'hC, 0, 0, 3, 2); tick();
    drv(0, 0, 0, 1, 0, 1, 2);     tick();
    tick();
    tick();

    // steady push/pop at count 1, pointers wrap
    drv(1, 9, 32'h100, 0, 0, 9, 0); tick();
    for (int i = 0; i < 8; i++) begin
      drv(1, 5'(10 + i), 32'h200 + 32'(i), 1, 0, 5'(10 + i), 5'(9 + i));
      tick();
    end
    drv(0, 0, 0, 1, 0, 0, 0); tick();
    tick();

    // rd=0 result is consumed without a push
    drv(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0);             tick();

    // two entries for the same rd: youngest forwards
    drv(1, 7, 32'h11, 0, 0, 7, 8); tick();
    drv(1, 7, 32'h22, 0, 0, 7, 8); tick();
    drv(0, 0, 0, 0, 0, 7, 8);      tick();

    // flush while full with a concurrent push
    drv(1, 4, 32'h33, 1, 1, 7, 4); tick();
    drv(0, 0, 0, 0, 0, 7, 4);      tick();

    // reset while full with a concurrent push
    drv(1, 6, 32'h44, 0, 0, 6, 5); tick();
    drv(1, 5, 32'h55, 0, 0, 6, 5); tick();
    drv(1, 3, 32'h66, 1, 0, 6, 5); rst_n = 1'b0; tick();
    tick();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 6, 5);      tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 1, 0, 0, 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_wb_buffer.md
Name: mul_wb_buffer

Overview:
Result/writeback buffer directly downstream of the multiplier/MAC unit. It captures each completed multiplier result with its destination register, holds it in a small FIFO until the register-file write port grants it, and back-pressures the multiplier through the multiplier's ex_ready_i input. It also exposes a forwarding lookup so the decode stage can bypass pending multiplier results.

Parameters:
DEPTH, 2, number of buffered results; power of two, >= 2
DATA_W, 32, result width
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
mul_valid_i  in  1  multiplier result valid (multiplier enable_i & ready_o)
mul_result_i  in  DATA_W  multiplier result_o
mul_rd_i  in  5  destination register of the result
ex_ready_o  out  1  buffer can accept; drives multiplier ex_ready_i
flush_i  in  1  pipeline flush; discards all buffered results
wb_valid_o  out  1  head entry valid for writeback
wb_rd_o  out  5  head entry destination
wb_data_o  out  DATA_W  head entry data
wb_ready_i  in  1  register-file write port granted this cycle
fwd_rs1_i  in  5  decode source register 1
fwd_rs2_i  in  5  decode source register 2
fwd_hit1_o  out  1  rs1 matches a buffered entry
fwd_hit2_o  out  1  rs2 matches a buffered entry
fwd_data1_o  out  DATA_W  forwarded value for rs1
fwd_data2_o  out  DATA_W  forwarded value for rs2
count_o  out  CNT_W  current occupancy

Behaviour:
- Reset: rst_n sampled low at clk edge -> rd_ptr=wr_ptr=0, count=0, all entry valid bits 0. After reset: wb_valid_o=0, wb_rd_o=0, wb_data_o=0, fwd_hit*=0, fwd_data*=0, count_o=0, ex_ready_o=1. While rst_n is low, ex_ready_o is forced to 0.
- Reset mid-operation: all entries are discarded and nothing is written back; reset has priority over flush, push and pop.
- ex_ready_o = (count != DEPTH) & rst_n. There is no combinational path from wb_ready_i or flush_i to ex_ready_o.
- Accept: mul_valid_i & ex_ready_o.
  - Accepted with mul_rd_i != 0: push {rd, data} at wr_ptr; wr_ptr increments.
  - Accepted with mul_rd_i == 0: result is consumed and discarded; no push, count unchanged.
- Pop: wb_valid_o & wb_ready_i; rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy 0..DEPTH.
- Push and pop in the same cycle: both occur; count unchanged. This is legal at any count < DEPTH. At count == DEPTH only the pop occurs.
- Latency: accept in cycle N -> wb_valid_o=1 in cycle N+1. There is no same-cycle bypass to the wb outputs.
- wb_valid_o = (count != 0). wb_rd_o and wb_data_o show the head entry, and show 0 when the buffer is empty.
- Head stability: head data is held stable while wb_valid_o & !wb_ready_i.
- Flush: flush_i=1 at edge -> count=0, pointers=0, valid bits cleared. A push or pop in the same cycle is ignored. wb_valid_o=0 in the next cycle.
- Forwarding is combinational over valid entries.
  - hit = any valid entry with rd == rs and rs != 0.
  - If several entries match, the youngest (closest to wr_ptr) wins.
  - Data is 0 when there is no hit.
  - An entry that is popping this cycle still hits this cycle.
  - A result being accepted this cycle does not hit until the next cycle.
- Data width: the result is stored unmodified; no sign extension or truncation.

Decomposition:
- riscv_pkg additions:
  - localparam MUL_WB_DEPTH = 2.
  - typedef struct packed {logic [4:0] rd; logic [31:0] data;} mul_wb_entry_t.
  - MUL_WB_CNT_W constant.
- Sub-module mul_wb_fwd: parameterized youngest-match priority lookup over the entry array plus valid vector and wr_ptr. Instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset then a single push (rd=5, data=0x12345678) with wb_ready_i=1 -> wb_valid_o=1 with rd=5, data=0x12345678 exactly one cycle later; count_o returns to 0 after the pop.
- Fill with wb_ready_i=0: pushes rd=1/0xA, rd=2/0xB -> count_o=2, ex_ready_o=0; a third mul_valid_i is not accepted. Raise wb_ready_i -> pops in order 0xA then 0xB; ex_ready_o=1 in the cycle after the first pop.
- Simultaneous push/pop at count=1 across 8 consecutive cycles -> count_o stays 1 and pointers wrap; the written-back data sequence equals the pushed sequence.
- rd=0 push (data=0xFFFF_FFFF) -> accepted (ex_ready_o=1), count_o unchanged, no wb_valid_o; fwd_rs1_i=0 -> fwd_hit1_o=0.
- Forwarding: buffer holds rd=7/0x11 (older) and rd=7/0x22 (younger); fwd_rs1_i=7 -> hit1=1, data1=0x22; fwd_rs2_i=8 -> hit2=0, data2=0.
- Flush with count=2 plus a concurrent push -> next cycle count_o=0, wb_valid_o=0, no hits. Separately, asserting rst_n=0 with count=2 behaves identically, and ex_ready_o=0 while rst_n is low.
